// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the bridge FIFOs.
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  // Bit positions of the error flags inside the bridge status register.
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UDF_BIT = 1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo_flex_if.sv
// sync_fifo_flex_if: FIFO data/handshake/status bundle; peak_count exists only with FIFO_PEAK_TRACK_EN.
interface sync_fifo_flex_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CNT_W = clog2(DEPTH) + 1;
  logic flush;
  logic [WIDTH-1:0] wr_data;
  logic wr_en;
  logic full;
  logic almost_full;
  logic rd_en;
  logic [WIDTH-1:0] rd_data;
  logic empty;
  logic almost_empty;
  logic [CNT_W-1:0] count;
  logic overflow;
  logic underflow;
  logic clr_err;
`ifdef FIFO_PEAK_TRACK_EN
  logic [CNT_W-1:0] peak_count;
  modport master (output flush, wr_data, wr_en, rd_en, clr_err,
                  input full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow, peak_count);
  modport slave (input flush, wr_data, wr_en, rd_en, clr_err,
                 output full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow, peak_count);
`else
  modport master (output flush, wr_data, wr_en, rd_en, clr_err,
                  input full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow);
  modport slave (input flush, wr_data, wr_en, rd_en, clr_err,
                 output full, almost_full, rd_data, empty, almost_empty, count, overflow, underflow);
`endif
endinterface

// File: rtl/fifo_flag_gen.sv
// fifo_flag_gen: occupancy and status flags derived from wrap-bit pointers.
module fifo_flag_gen #(
  parameter int ADDR_W = 4,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 1
) (
  input  logic [ADDR_W:0] wr_ptr,
  input  logic [ADDR_W:0] rd_ptr,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [ADDR_W:0] count
);
  localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE = (ADDR_W+1)'(AE_THRESH);
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full = count >= AF;
  assign almost_empty = count <= AE;
endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: parametrised FWFT FIFO with flush and sticky errors.
// Optional FIFO_PEAK_TRACK_EN adds a peak occupancy register on bus.peak_count.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input logic clk,
  input logic rst_n,
  sync_fifo_flex_if.slave bus
);
  localparam int ADDR_W = clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, count;
  logic full, empty, almost_full, almost_empty, wr_accept, rd_accept, overflow, underflow;
  fifo_flag_gen #(.ADDR_W(ADDR_W), .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)) u_flags (
    .wr_ptr(wr_ptr), .rd_ptr(rd_ptr), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count)
  );
  assign rd_accept = bus.rd_en && !empty;
  assign wr_accept = bus.wr_en && (!full || rd_accept);
  // Flush wins over both handshakes: nothing is stored, popped or flagged.
  assign wr_nxt = bus.flush ? '0 : wr_ptr + {{ADDR_W{1'b0}}, wr_accept};
  assign rd_nxt = bus.flush ? '0 : rd_ptr + {{ADDR_W{1'b0}}, rd_accept};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      overflow <= (bus.wr_en && !wr_accept && !bus.flush) || (overflow && !bus.clr_err);
      underflow <= (bus.rd_en && !rd_accept && !bus.flush) || (underflow && !bus.clr_err);
    end
  end
  always_ff @(posedge clk)
    if (wr_accept && !bus.flush) mem[wr_ptr[ADDR_W-1:0]] <= bus.wr_data;
  assign bus.rd_data = mem[rd_ptr[ADDR_W-1:0]];
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.almost_full = almost_full;
  assign bus.almost_empty = almost_empty;
  assign bus.count = count;
  assign bus.overflow = overflow;
  assign bus.underflow = underflow;
`ifdef FIFO_PEAK_TRACK_EN
  logic [ADDR_W:0] peak, next_count;
  assign next_count = wr_nxt - rd_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) peak <= '0;
    else peak <= (bus.flush || bus.clr_err) ? '0 : (next_count > peak ? next_count : peak);
  assign bus.peak_count = peak;
`endif
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed vector table plus hand sequences for sync_fifo_flex.
module tb_sync_fifo_flex;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_nb = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;

  sync_fifo_flex_if #(.WIDTH(8), .DEPTH(16)) a ();
  sync_fifo_flex_if #(.WIDTH(12), .DEPTH(4)) b ();
  sync_fifo_flex #(.WIDTH(8), .DEPTH(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
  sync_fifo_flex #(.WIDTH(12), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(0)) dut_b (.clk(clk), .rst_n(rst_nb), .bus(b));

  typedef struct {
    logic rst;
    logic wr, rd, fl, ce;
    logic [7:0] wd;
    logic [4:0] cnt;
    logic ov, ud, dv;
    logic [7:0] rdx;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string t, input logic [4:0] cnt, input logic ov, input logic ud,
                       input logic dv, input logic [7:0] rdx);
    chk({t, ".count"}, 32'(a.count), 32'(cnt));
    chk({t, ".empty"}, 32'(a.empty), 32'(cnt == 0));
    chk({t, ".full"}, 32'(a.full), 32'(cnt == 16));
    chk({t, ".almost_full"}, 32'(a.almost_full), 32'(cnt >= 14));
    chk({t, ".almost_empty"}, 32'(a.almost_empty), 32'(cnt <= 1));
    chk({t, ".overflow"}, 32'(a.overflow), 32'(ov));
    chk({t, ".underflow"}, 32'(a.underflow), 32'(ud));
    if (dv) chk({t, ".rd_data"}, 32'(a.rd_data), 32'(rdx));
  endtask

  task automatic chk_b(input string t, input logic [2:0] cnt);
    chk({t, ".count"}, 32'(b.count), 32'(cnt));
    chk({t, ".empty"}, 32'(b.empty), 32'(cnt == 0));
    chk({t, ".full"}, 32'(b.full), 32'(cnt == 4));
    chk({t, ".almost_full"}, 32'(b.almost_full), 32'(cnt >= 3));
    chk({t, ".almost_empty"}, 32'(b.almost_empty), 32'(cnt == 0));
  endtask

  task automatic drive_a(input logic wr, input logic rd, input logic fl, input logic ce, input logic [7:0] wd);
    a.wr_en = wr; a.rd_en = rd; a.flush = fl; a.clr_err = ce; a.wr_data = wd;
  endtask

  task automatic step_a(input logic wr, input logic rd, input logic fl, input logic ce, input logic [7:0] wd);
    drive_a(wr, rd, fl, ce, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic wr, input logic rd, input logic [11:0] wd);
    b.wr_en = wr; b.rd_en = rd; b.wr_data = wd;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic wr, input logic rd, input logic fl, input logic ce,
                              input logic [7:0] wd, input logic [4:0] cnt, input logic ov, input logic ud,
                              input logic dv, input logic [7:0] rdx);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.fl = fl; v.ce = ce; v.wd = wd;
    v.cnt = cnt; v.ov = ov; v.ud = ud; v.dv = dv; v.rdx = rdx;
    return v;
  endfunction

  initial begin
    drive_a(0, 0, 0, 0, 8'h00);
    b.flush = 1'b0; b.clr_err = 1'b0; b.wr_en = 1'b0; b.rd_en = 1'b0; b.wr_data = '0;
    // Fill 0x01..0x10, then one rejected write.
    for (int i = 1; i <= 16; i++) vq.push_back(mk(i == 1, 1, 0, 0, 0, 8'(i), 5'(i), 0, 0, 1, 8'h01));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h11, 16, 1, 0, 1, 8'h01));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h00, 16, 0, 0, 1, 8'h01));
    // Full read+write streaming across the pointer wrap.
    for (int k = 0; k < 20; k++)
      vq.push_back(mk(0, 1, 1, 0, 0, 8'(8'h20 + k), 16, 0, 0, 1, (k + 1 < 16) ? 8'(k + 2) : 8'(8'h20 + k - 15)));
    // Read of empty with simultaneous write.
    vq.push_back(mk(1, 1, 1, 0, 0, 8'hA5, 1, 0, 1, 1, 8'hA5));
    for (int i = 0; i < 4; i++) vq.push_back(mk(0, 1, 0, 0, 0, 8'(8'h31 + i), 5'(i + 2), 0, 1, 1, 8'hA5));
    // Flush overrides wr/rd and leaves error flags alone.
    vq.push_back(mk(0, 1, 1, 1, 0, 8'h99, 0, 0, 1, 0, 8'h00));
    vq.push_back(mk(0, 1, 0, 0, 0, 8'h77, 1, 0, 1, 1, 8'h77));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h00, 1, 0, 0, 1, 8'h77));
    vq.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00));
    // New underflow in the same cycle as clr_err: set wins.
    vq.push_back(mk(0, 0, 1, 0, 1, 8'h00, 0, 0, 1, 0, 8'h00));
    vq.push_back(mk(0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00));
    // Rejected write during clr_err: overflow set wins.
    for (int i = 0; i < 16; i++) vq.push_back(mk(0, 1, 0, 0, 0, 8'(8'h40 + i), 5'(i + 1), 0, 0, 1, 8'h40));
    vq.push_back(mk(0, 1, 0, 0, 1, 8'hEE, 16, 1, 0, 1, 8'h40));
    vq.push_back(mk(0, 0, 0, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00));

    #2;
    chk_a("reset", 0, 0, 0, 0, 8'h00);
    rst_n = 1'b1;
    rst_nb = 1'b1;
    @(posedge clk);
    #1;
    foreach (vq[i]) begin
      if (vq[i].rst) begin
        rst_n = 1'b0;
        #2;
        chk_a($sformatf("rst%0d", i), 0, 0, 0, 0, 8'h00);
        rst_n = 1'b1;
      end
      step_a(vq[i].wr, vq[i].rd, vq[i].fl, vq[i].ce, vq[i].wd);
      chk_a($sformatf("v%0d", i), vq[i].cnt, vq[i].ov, vq[i].ud, vq[i].dv, vq[i].rdx);
    end
    drive_a(0, 0, 0, 0, 8'h00);

    // Small FIFO: threshold sweep 0..4..0 with a full read+write in the middle.
    chk_b("b_reset", 0);
    for (int i = 0; i < 4; i++) begin
      step_b(1, 0, 12'(12'h100 + i));
      chk_b($sformatf("b_fill%0d", i), 3'(i + 1));
    end
    step_b(1, 1, 12'h104);
    chk_b("b_fullrw", 4);
    chk("b_fullrw.rd_data", 32'(b.rd_data), 32'h101);
    chk("b_fullrw.overflow", 32'(b.overflow), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_head%0d", i), 32'(b.rd_data), 32'(12'h101 + i));
      step_b(0, 1, 12'h000);
      chk_b($sformatf("b_drain%0d", i), 3'(3 - i));
    end
    step_b(1, 0, 12'h200);
    step_b(1, 0, 12'h201);
    b.wr_en = 1'b0;
    chk_b("b_pre_rst", 2);
    #3;
    rst_nb = 1'b0;
    #1;
    chk_b("b_async_rst", 0);
    #1;
    rst_nb = 1'b1;

`ifdef FIFO_PEAK_TRACK_EN
    rst_n = 1'b0;
    #1;
    chk("peak_reset", 32'(a.peak_count), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) step_a(1, 0, 0, 0, 8'(i));
    for (int i = 0; i < 7; i++) step_a(0, 1, 0, 0, 8'h00);
    chk("peak_count", 32'(a.count), 32'h2);
    chk("peak_max", 32'(a.peak_count), 32'h9);
    step_a(0, 0, 0, 1, 8'h00);
    chk("peak_clr", 32'(a.peak_count), 32'h0);
    step_a(0, 0, 0, 0, 8'h00);
    chk("peak_reload", 32'(a.peak_count), 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Parametrised synchronous FWFT FIFO. Successor to the fixed 16-deep bridge FIFO, used on both the I2C-to-SPI and SPI-to-I2C data paths of the bridge.
- Depth is any power of two; pointer and count widths are derived from it.
- Adds programmable almost-full/almost-empty flags, a synchronous flush, sticky overflow/underflow error flags, and read+write while full.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of FIFO contents
wr_data  in  WIDTH  write data
wr_en  in  1  write request
full  out  1  no free entries
almost_full  out  1  count >= AF_THRESH
rd_en  in  1  read request (pops the head word)
rd_data  out  WIDTH  head word, first-word-fall-through
empty  out  1  no valid entries
almost_empty  out  1  count <= AE_THRESH
count  out  CNT_W  occupancy 0..DEPTH, CNT_W = $clog2(DEPTH)+1
overflow  out  1  sticky: write attempted and rejected
underflow  out  1  sticky: read attempted and rejected
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async, rst_n low):
  - wr_ptr = rd_ptr = 0; count = 0; empty = 1; full = 0; almost_empty = 1.
  - almost_full = 0 (AF_THRESH >= 1 guarantees this); overflow = underflow = 0.
  - Memory array is not reset.
- Pointers are ADDR_W+1 bits wide, ADDR_W = $clog2(DEPTH); the MSB is the wrap bit.
  - full: MSBs differ and lower bits are equal. empty: pointers are equal. count = wr_ptr - rd_ptr, modulo 2^CNT_W.
  - All flags and count are combinational from registered pointers. No output is registered separately.
- Write acceptance: wr_accept = wr_en && (!full || rd_accept).
  - Writing while full is allowed in the same cycle as an accepted read; count stays DEPTH.
  - On accept, mem[wr_ptr] is written and wr_ptr increments at the clock edge.
- Read acceptance: rd_accept = rd_en && !empty.
  - Reading an empty FIFO is rejected even if wr_en is high in the same cycle; the written word is still stored.
- FWFT output:
  - rd_data = mem[rd_ptr] combinationally. The value is don't-care while empty.
  - Latency from a write into an empty FIFO to empty=0 with valid rd_data is one clock edge.
- Simultaneous accepted read and write: both pointers increment and count is unchanged.
- Wrap-around: pointers roll from 2*DEPTH-1 to 0 with no special handling.
- Error flags:
  - overflow sets on wr_en && !wr_accept. underflow sets on rd_en && !rd_accept.
  - Each stays set until clr_err=1 or reset.
  - If clr_err and a new error occur in the same cycle, the flag ends the cycle set (set wins).
- Flush:
  - When flush=1, wr_ptr and rd_ptr become 0 at the edge.
  - Overrides wr_en/rd_en in that cycle; no write and no pop occur and no error is flagged.
  - Error flags are otherwise unchanged by flush.
- Reset asserted mid-transfer: contents are lost and all outputs return to reset values immediately (asynchronous).

Optional Feature:
Macro FIFO_PEAK_TRACK_EN.
- Defined: adds output peak_count [CNT_W] holding the maximum count seen since reset, flush or clr_err.
  - Updated at each edge with max(peak_count, next_count).
  - Cleared to 0 by reset; flush and clr_err load 0.
- Undefined: the port and register do not exist; all other behaviour is identical.

Decomposition:
- Shared package/header fifo_pkg:
  - clog2 helper function.
  - Default WIDTH/DEPTH constants for the bridge.
  - Error-flag bit indices, used when both flags are packed into the bridge status register.
- Sub-module fifo_flag_gen:
  - Inputs: pointers and thresholds.
  - Outputs: full, empty, almost_full, almost_empty and count, combinationally.
  - Reused by the planned async FIFO.
- Storage and pointer registers stay in the top module.

Test Plan:
1. Reset, then write 0x01..0x10 (DEPTH=16) with no reads: full=1 after 16th edge, count=16, almost_full=1 from count 14; a 17th write sets overflow=1 and count stays 16.
2. From full, hold wr_en=rd_en=1 for 20 cycles with an incrementing write value: count stays 16, rd_data sequence has no gaps, pointers wrap, overflow stays 0.
3. Empty FIFO, rd_en=1 with wr_en=1 writing 0xA5: underflow=1; next cycle empty=0, count=1, rd_data=0xA5.
4. Load 5 words, assert flush together with wr_en=1 and rd_en=1: next cycle count=0, empty=1, overflow/underflow unchanged; then clr_err=1 clears both flags.
5. DEPTH=4, WIDTH=12, AF_THRESH=3, AE_THRESH=0: sweep count 0..4..0 and check each flag against its threshold every cycle; pull rst_n low while count=2 and see empty=1 and count=0 without waiting for a clock edge.
6. With FIFO_PEAK_TRACK_EN: fill to 9, drain to 2, and check peak_count=9; after clr_err, peak_count=0 on that edge, and the next edge loads the current count (2).
